// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, fixed 34-cycle latency.
// Writes the result to the register file on a single-cycle done pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; inputs captured on the accepting edge
// S_CALC | 32 shift-add (mul) or restoring-subtract (div) steps
// S_DONE | done pulse; register-file write unless rd is x0
module mdu_iterative (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic        w_en,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_neg;
  logic        r_rem_neg;

  logic        w_is_div;
  logic        w_a_sgn;
  logic        w_b_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_sub;
  logic        w_div_ok;
  logic [31:0] w_hi_nx;
  logic [31:0] w_lo_nx;
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_result;

  // Operand sign handling at capture: MULH both signed, MULHSU rs1 only, DIV/REM both.
  assign w_is_div = funct3[2];
  assign w_a_sgn  = w_is_div ? ~funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
  assign w_b_sgn  = w_is_div ? ~funct3[0] : (funct3 == 3'b001);
  assign w_a_neg  = w_a_sgn & rs1_data[31];
  assign w_b_neg  = w_b_sgn & rs2_data[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - rs1_data) : rs1_data;
  assign w_b_mag  = w_b_neg ? (32'd0 - rs2_data) : rs2_data;

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_div_shift = {r_hi, r_lo[31]};
  assign w_div_sub   = w_div_shift - {1'b0, r_b};
  assign w_div_ok    = ~w_div_sub[32];

  // r_hi/r_lo hold {accumulator, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_op[2]) begin
      w_hi_nx = w_div_ok ? w_div_sub[31:0] : w_div_shift[31:0];
      w_lo_nx = {r_lo[30:0], w_div_ok};
    end else begin
      w_hi_nx = w_mul_sum[32:1];
      w_lo_nx = {w_mul_sum[0], r_lo[31:1]};
    end
  end

  assign w_prod   = {w_hi_nx, w_lo_nx};
  assign w_prod_s = r_neg ? (64'd0 - w_prod) : w_prod;
  assign w_quo    = r_neg ? (32'd0 - w_lo_nx) : w_lo_nx;
  assign w_rem    = r_rem_neg ? (32'd0 - w_hi_nx) : w_hi_nx;

  always_comb begin
    w_result = 32'd0;
    case (r_op)
      3'b000:                 w_result = w_prod_s[31:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod_s[63:32];
      3'b100, 3'b101:         w_result = w_quo;
      default:                w_result = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_op      <= 3'd0;
      r_rd      <= 5'd0;
      r_b       <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_en      <= 1'b0;
      w_addr    <= 5'd0;
      w_data    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CALC;
            r_cnt     <= 5'd0;
            r_op      <= funct3;
            r_rd      <= rd_addr;
            r_hi      <= 32'd0;
            r_b       <= w_is_div ? w_b_mag : w_a_mag;
            r_lo      <= w_is_div ? w_a_mag : w_b_mag;
            // A zero divisor keeps the all-ones quotient unsigned.
            r_neg     <= (w_a_neg ^ w_b_neg) & ~(w_is_div & (rs2_data == 32'd0));
            r_rem_neg <= w_a_neg;
            busy      <= 1'b1;
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            w_en    <= (r_rd != 5'd0);
            w_addr  <= r_rd;
            w_data  <= w_result;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          w_en    <= 1'b0;
          w_addr  <= 5'd0;
          w_data  <= 32'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: expected writes queued at start, checked on done.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        busy;
  logic        done;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        wen;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail = 0;

  mdu_iterative dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .w_en(w_en), .w_addr(w_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sbv, ub;
    int          ia, ib;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    p   = 64'd0;
    case (f)
      3'd0: begin p = 64'(sa * sbv); return p[31:0]; end
      3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic push_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    e.addr = rd;
    e.data = model(f, a, b);
    e.wen  = (rd != 5'd0);
    q_exp.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q_exp.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          chk("w_en", 64'(w_en), 64'(e.wen));
          chk("w_addr", 64'(w_addr), 64'(e.addr));
          chk("w_data", 64'(w_data), 64'(e.data));
        end
      end else begin
        chk("idle_outs", {27'd0, w_en, w_addr, w_data}, 64'd0);
      end
    end
  end

  // Called at the start of cycle 0 (or mid-cycle just before the accepting edge).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit pulse_mid);
    push_exp(f, a, b, rd);
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
      end
      if (pulse_mid && c == 10) begin
        start = 1'b1; funct3 = 3'd3; rs1_data = 32'h1234_5678; rs2_data = 32'h9abc_def0;
      end
      if (pulse_mid && c == 11) start = 1'b0;
      chk("busy", 64'(busy), 64'(c <= 33));
      chk("done", 64'(done), 64'(c == 33));
    end
  endtask

  initial begin
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_outs", {27'd0, w_en, w_addr, w_data}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 1'b0);
    run_op(3'd5, 32'h0000_0005, 32'h0000_0000, 5'd11, 1'b0);
    run_op(3'd7, 32'h0000_0005, 32'h0000_0000, 5'd12, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
    run_op(3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 5'd15, 1'b0);
    run_op(3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 5'd16, 1'b0);

    run_op(3'd0, 32'd123, 32'd456, 5'd17, 1'b1);
    run_op(3'd5, 32'd1000, 32'd7, 5'd0, 1'b0);

    // Abort a DIV with reset in cycle 12.
    funct3 = 3'd4; rs1_data = 32'hFFFF_FF9C; rs2_data = 32'd3; rd_addr = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    chk("rstmid_outs", {27'd0, w_en, w_addr, w_data}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd4, 32'hFFFF_FF9C, 32'd3, 5'd3, 1'b0);

    // start held high across two operations.
    push_exp(3'd0, 32'd1001, 32'd2003, 5'd20);
    push_exp(3'd7, 32'hDEAD_BEEF, 32'd97, 5'd21);
    funct3 = 3'd0; rs1_data = 32'd1001; rs2_data = 32'd2003; rd_addr = 5'd20; start = 1'b1;
    for (int c = 1; c <= 68; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin funct3 = 3'd7; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'd97; rd_addr = 5'd21; end
      if (c == 68) start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'((c <= 33) || (c >= 35 && c <= 67)));
      chk("b2b_done", 64'(done), 64'(c == 33 || c == 67));
    end

    for (int k = 0; k < 16; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (k % 4 == 1) b = 32'($urandom_range(0, 9));
      if (k % 4 == 2) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
      run_op(3'($urandom), a, b, 5'($urandom_range(1, 31)), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(q_exp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
